// File: rtl/hqm_reset_pwr_responder.sv
// HQM core-domain power/reset responder: sequences isolation, clock enable, fuse pull and
// core reset release for power-up, warm reset and power-down, with 4-phase acks to the agent.
module hqm_reset_pwr_responder #(
    parameter int RST_HOLD_CYC = 16,
    parameter int FUSE_TMO_CYC = 1024,
    parameter int CNT_W        = 11
) (
    input  logic       side_clk,
    input  logic       side_rst_b,
    input  logic       pwr_on_req,
    output logic       pwr_on_ack,
    input  logic       warm_rst_req,
    output logic       warm_rst_ack,
    input  logic       fuse_bypass,
    output logic       fuse_pull_req,
    input  logic       fuse_pull_ack,
    output logic       quiesce_req,
    input  logic       quiesce_ack,
    output logic       core_rst_b,
    output logic       core_clk_en,
    output logic       iso_en,
    output logic       fuse_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        FUSE      = 3'd1,
        RST_HOLD  = 3'd2,
        ACTIVE    = 3'd3,
        WARM_QSC  = 3'd4,
        WARM_HOLD = 3'd5,
        DOWN_QSC  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] FUSE_LAST = CNT_W'(FUSE_TMO_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             drop;

    assign state = st;

    // Power removed while still bringing up, or in the middle of a warm reset.
    assign drop = !pwr_on_req &&
                  (st == FUSE || st == RST_HOLD || st == WARM_QSC || st == WARM_HOLD);

    always_ff @(posedge side_clk or negedge side_rst_b) begin
        if (!side_rst_b) begin
            st            <= OFF;
            cnt           <= '0;
            pwr_on_ack    <= 1'b0;
            warm_rst_ack  <= 1'b0;
            fuse_pull_req <= 1'b0;
            quiesce_req   <= 1'b0;
            core_rst_b    <= 1'b0;
            core_clk_en   <= 1'b0;
            iso_en        <= 1'b1;
            fuse_err      <= 1'b0;
        end else begin
            // Counter saturates; every state transition below clears it.
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (!warm_rst_req) warm_rst_ack <= 1'b0;

            if (drop) begin
                st            <= OFF;
                cnt           <= '0;
                fuse_pull_req <= 1'b0;
                quiesce_req   <= 1'b0;
                core_rst_b    <= 1'b0;
                core_clk_en   <= 1'b0;
                iso_en        <= 1'b1;
                pwr_on_ack    <= 1'b0;
                warm_rst_ack  <= 1'b0;
            end else begin
                unique case (st)
                    OFF: begin
                        if (pwr_on_req && !pwr_on_ack) begin
                            iso_en      <= 1'b0;
                            core_clk_en <= 1'b1;
                            cnt         <= '0;
                            if (fuse_bypass) begin
                                st <= RST_HOLD;
                            end else begin
                                st            <= FUSE;
                                fuse_pull_req <= 1'b1;
                            end
                        end
                    end
                    FUSE: begin
                        // A late ack on the timeout cycle still counts as success.
                        if (fuse_pull_ack || cnt == FUSE_LAST) begin
                            fuse_pull_req <= 1'b0;
                            cnt           <= '0;
                            st            <= RST_HOLD;
                            if (!fuse_pull_ack) fuse_err <= 1'b1;
                        end
                    end
                    RST_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            core_rst_b <= 1'b1;
                            pwr_on_ack <= 1'b1;
                            cnt        <= '0;
                            st         <= ACTIVE;
                        end
                    end
                    ACTIVE: begin
                        if (!pwr_on_req) begin
                            quiesce_req <= 1'b1;
                            cnt         <= '0;
                            st          <= DOWN_QSC;
                        end else if (warm_rst_req && !warm_rst_ack) begin
                            quiesce_req <= 1'b1;
                            cnt         <= '0;
                            st          <= WARM_QSC;
                        end
                    end
                    WARM_QSC: begin
                        if (quiesce_ack) begin
                            quiesce_req <= 1'b0;
                            core_rst_b  <= 1'b0;
                            cnt         <= '0;
                            st          <= WARM_HOLD;
                        end
                    end
                    WARM_HOLD: begin
                        if (cnt == HOLD_LAST) begin
                            core_rst_b   <= 1'b1;
                            warm_rst_ack <= 1'b1;
                            cnt          <= '0;
                            st           <= ACTIVE;
                        end
                    end
                    DOWN_QSC: begin
                        if (quiesce_ack) begin
                            quiesce_req <= 1'b0;
                            core_rst_b  <= 1'b0;
                            core_clk_en <= 1'b0;
                            iso_en      <= 1'b1;
                            pwr_on_ack  <= 1'b0;
                            cnt         <= '0;
                            st          <= OFF;
                        end
                    end
                    default: st <= OFF;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hqm_reset_pwr_responder.sv
// Directed test-plan scenarios followed by randomized agent traffic, all checked cycle by
// cycle against a countdown-timer reference model of the sequencing rules.
module tb_hqm_reset_pwr_responder;

    localparam int HOLD = 16;
    localparam int TMO  = 1024;
    localparam logic [10:0] RST_VEC = 11'b000_0_1_0_0_0_0_0_0;

    logic       side_clk = 1'b0;
    logic       side_rst_b;
    logic       pwr_on_req, warm_rst_req, fuse_bypass, fuse_pull_ack, quiesce_ack;
    logic       pwr_on_ack, warm_rst_ack, fuse_pull_req, quiesce_req;
    logic       core_rst_b, core_clk_en, iso_en, fuse_err;
    logic [2:0] state;

    hqm_reset_pwr_responder #(.RST_HOLD_CYC(HOLD), .FUSE_TMO_CYC(TMO), .CNT_W(11)) dut (
        .side_clk(side_clk), .side_rst_b(side_rst_b),
        .pwr_on_req(pwr_on_req), .pwr_on_ack(pwr_on_ack),
        .warm_rst_req(warm_rst_req), .warm_rst_ack(warm_rst_ack),
        .fuse_bypass(fuse_bypass), .fuse_pull_req(fuse_pull_req), .fuse_pull_ack(fuse_pull_ack),
        .quiesce_req(quiesce_req), .quiesce_ack(quiesce_ack),
        .core_rst_b(core_rst_b), .core_clk_en(core_clk_en), .iso_en(iso_en),
        .fuse_err(fuse_err), .state(state)
    );

    always #5 side_clk = ~side_clk;

    int n_chk = 0, n_pass = 0;
    bit saw_fpr, saw_wack, saw_clk_off, mute;

    // reference model: state code, output levels, elapsed fuse wait, remaining hold cycles
    int m_st, m_elapsed, m_hold_left;
    bit m_ack, m_wack, m_fpr, m_qreq, m_rst, m_clk, m_iso, m_ferr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [10:0] obs_vec();
        return {state, fuse_err, iso_en, core_clk_en, core_rst_b,
                quiesce_req, fuse_pull_req, warm_rst_ack, pwr_on_ack};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {m_st[2:0], m_ferr, m_iso, m_clk, m_rst, m_qreq, m_fpr, m_wack, m_ack};
    endfunction

    task automatic m_reset();
        m_st = 0; m_elapsed = 0; m_hold_left = 0;
        m_ack = 0; m_wack = 0; m_fpr = 0; m_qreq = 0;
        m_rst = 0; m_clk = 0; m_iso = 1; m_ferr = 0;
    endtask

    task automatic m_power_off();
        m_st = 0; m_fpr = 0; m_qreq = 0; m_rst = 0; m_clk = 0; m_iso = 1; m_ack = 0;
    endtask

    task automatic model_step();
        if (!side_rst_b) begin m_reset(); return; end
        if (!warm_rst_req) m_wack = 0;
        if (!pwr_on_req && (m_st == 1 || m_st == 2 || m_st == 4 || m_st == 5)) begin
            m_power_off(); m_wack = 0;
            return;
        end
        case (m_st)
            0: if (pwr_on_req && !m_ack) begin
                m_iso = 0; m_clk = 1;
                if (fuse_bypass) begin m_st = 2; m_hold_left = HOLD; end
                else begin m_st = 1; m_fpr = 1; m_elapsed = 0; end
            end
            1: begin
                m_elapsed++;
                if (fuse_pull_ack || m_elapsed == TMO) begin
                    if (!fuse_pull_ack) m_ferr = 1;
                    m_fpr = 0; m_st = 2; m_hold_left = HOLD;
                end
            end
            2: begin
                m_hold_left--;
                if (m_hold_left == 0) begin m_rst = 1; m_ack = 1; m_st = 3; end
            end
            3: if (!pwr_on_req) begin m_st = 6; m_qreq = 1; end
               else if (warm_rst_req && !m_wack) begin m_st = 4; m_qreq = 1; end
            4: if (quiesce_ack) begin m_qreq = 0; m_rst = 0; m_st = 5; m_hold_left = HOLD; end
            5: begin
                m_hold_left--;
                if (m_hold_left == 0) begin m_rst = 1; m_wack = 1; m_st = 3; end
            end
            6: if (quiesce_ack) m_power_off();
            default: ;
        endcase
    endtask

    task automatic cycle();
        @(posedge side_clk);
        model_step();
        #1;
        chk("outs", obs_vec(), exp_vec());
        chk("invariant", ((core_rst_b && !(core_clk_en && !iso_en)) ||
                          (quiesce_req && fuse_pull_req)) ? 1 : 0, 0);
        if (fuse_pull_req) saw_fpr = 1;
        if (warm_rst_ack) saw_wack = 1;
        if (!core_clk_en) saw_clk_off = 1;
    endtask

    task automatic wait_rel(output int n);
        n = 0;
        while (!core_rst_b && n < 2000) begin cycle(); n++; end
    endtask

    task automatic quiesce(input int dly);
        repeat (dly) cycle();
        quiesce_ack = 1; cycle(); quiesce_ack = 0;
    endtask

    task automatic drive_rand();
        if (m_st == 0) begin
            mute = ($urandom_range(0, 9) == 0);
            fuse_bypass = 1'($urandom_range(0, 1));
        end
        fuse_pull_ack = m_fpr && !mute && ($urandom_range(0, 7) == 0);
        quiesce_ack   = m_qreq && ($urandom_range(0, 3) == 0);
        if (!pwr_on_req) begin
            if (m_st == 0 && $urandom_range(0, 7) == 0) pwr_on_req = 1;
        end else if (m_st == 3 ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 299) == 0)) begin
            pwr_on_req = 0;
        end
        if (!warm_rst_req) begin
            if (m_st == 3 && !m_wack && $urandom_range(0, 15) == 0) warm_rst_req = 1;
        end else if ((m_wack || m_st == 0) && $urandom_range(0, 3) == 0) begin
            warm_rst_req = 0;
        end
    endtask

    initial begin
        int n;
        side_rst_b = 0; pwr_on_req = 0; warm_rst_req = 0; fuse_bypass = 0;
        fuse_pull_ack = 0; quiesce_ack = 0; mute = 0;
        m_reset();
        #12;
        chk("reset_vec", obs_vec(), RST_VEC);
        @(negedge side_clk); side_rst_b = 1;

        // bypass power-up
        saw_fpr = 0; fuse_bypass = 1; pwr_on_req = 1;
        cycle();
        chk("bp_iso", iso_en, 0);
        chk("bp_clk_en", core_clk_en, 1);
        wait_rel(n);
        chk("bp_release_cyc", n, 16);
        chk("bp_ack", pwr_on_ack, 1);
        chk("bp_no_fuse", saw_fpr, 0);

        pwr_on_req = 0; cycle();
        chk("down_state", state, 6);
        quiesce(2);
        chk("down_off", state, 0);

        // fuse pull with ack 5 cycles after request
        fuse_bypass = 0; pwr_on_req = 1; cycle();
        chk("fp_req", fuse_pull_req, 1);
        repeat (4) cycle();
        fuse_pull_ack = 1; cycle(); fuse_pull_ack = 0;
        chk("fp_req_fall", fuse_pull_req, 0);
        chk("fp_state", state, 2);
        wait_rel(n);
        chk("fp_release_cyc", n, 16);
        chk("fp_no_err", fuse_err, 0);

        // warm reset
        saw_fpr = 0; saw_clk_off = 0; warm_rst_req = 1; cycle();
        chk("wr_state", state, 4);
        chk("wr_qreq", quiesce_req, 1);
        quiesce(2);
        chk("wr_rst_low", core_rst_b, 0);
        wait_rel(n);
        chk("wr_hold_cyc", n, 16);
        chk("wr_ack", warm_rst_ack, 1);
        chk("wr_clk_kept", saw_clk_off, 0);
        chk("wr_no_fuse", saw_fpr, 0);
        warm_rst_req = 0; cycle();
        chk("wr_ack_fall", warm_rst_ack, 0);

        // power-down wins over a simultaneous warm request
        saw_wack = 0; pwr_on_req = 0; warm_rst_req = 1; cycle();
        chk("sim_state", state, 6);
        quiesce(1);
        chk("sim_clk_en", core_clk_en, 0);
        chk("sim_iso", iso_en, 1);
        chk("sim_ack", pwr_on_ack, 0);
        chk("sim_off", state, 0);
        chk("sim_no_wack", saw_wack, 0);
        warm_rst_req = 0;

        // fuse timeout, sticky error
        pwr_on_req = 1; cycle();
        n = 0;
        while (fuse_pull_req && n < 1200) begin cycle(); n++; end
        chk("tmo_cyc", n, TMO);
        chk("tmo_err", fuse_err, 1);
        wait_rel(n);
        chk("tmo_release_cyc", n, 16);
        pwr_on_req = 0; cycle(); quiesce(0);
        fuse_bypass = 1; pwr_on_req = 1; cycle();
        wait_rel(n);
        chk("tmo_sticky", fuse_err, 1);
        chk("tmo_reup_ack", pwr_on_ack, 1);

        // abort during FUSE
        pwr_on_req = 0; cycle(); quiesce(1);
        fuse_bypass = 0; pwr_on_req = 1; cycle(); repeat (3) cycle();
        pwr_on_req = 0; cycle();
        chk("abort_state", state, 0);
        chk("abort_fpr", fuse_pull_req, 0);
        chk("abort_ack", pwr_on_ack, 0);

        // async reset in the middle of WARM_HOLD
        fuse_bypass = 1; pwr_on_req = 1; cycle(); wait_rel(n);
        warm_rst_req = 1; cycle(); quiesce(0); repeat (5) cycle();
        chk("ar_in_hold", state, 5);
        #3 side_rst_b = 0;
        #1 m_reset();
        chk("ar_vec", obs_vec(), RST_VEC);
        warm_rst_req = 0; pwr_on_req = 0;
        @(negedge side_clk); side_rst_b = 1;

        repeat (6000) begin
            drive_rand();
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hqm_reset_pwr_responder.md
Name: hqm_reset_pwr_responder

Overview:
DUT-side responder that services the power-up, power-down, warm-reset and fuse-pull requests issued by the reset agent. It sequences the HQM core domain in a fixed order: isolation, then clock enable, then fuse pull, then core reset release. It also sequences the reverse order on power-down. Each request is acknowledged with a 4-phase handshake. The block sits between the SoC power/reset interface and the HQM core reset/clock-gate distribution.

Parameters:
RST_HOLD_CYC, 16, number of cycles core_rst_b is held low (minimum 2) before release on power-up or warm reset.
FUSE_TMO_CYC, 1024, number of cycles to wait for fuse_pull_ack before declaring a fuse error.
CNT_W, 11, counter width; must satisfy 2^CNT_W > max(RST_HOLD_CYC, FUSE_TMO_CYC).

Ports:
side_clk  in  1  free-running clock.
side_rst_b  in  1  asynchronous active-low reset (powergood).
pwr_on_req  in  1  level request: 1 = power on, 0 = power off.
pwr_on_ack  out  1  4-phase ack for pwr_on_req.
warm_rst_req  in  1  level request for a warm reset.
warm_rst_ack  out  1  4-phase ack for warm_rst_req.
fuse_bypass  in  1  strap; 1 = skip the fuse pull.
fuse_pull_req  out  1  fuse pull request.
fuse_pull_ack  in  1  fuse pull complete.
quiesce_req  out  1  request to the core to drain traffic.
quiesce_ack  in  1  core drained.
core_rst_b  out  1  core domain reset, active low.
core_clk_en  out  1  core clock gate enable.
iso_en  out  1  isolation clamp enable.
fuse_err  out  1  sticky fuse-pull timeout flag.
state  out  3  current FSM state, for debug.

Behaviour:
- All inputs are synchronous to side_clk. All outputs are registered.
- Reset values: pwr_on_ack=0, warm_rst_ack=0, fuse_pull_req=0, quiesce_req=0, core_rst_b=0, core_clk_en=0, iso_en=1, fuse_err=0, state=OFF(0).
- State encoding: OFF=0, FUSE=1, RST_HOLD=2, ACTIVE=3, WARM_QSC=4, WARM_HOLD=5, DOWN_QSC=6.
- OFF:
  - All core controls are in their reset values; pwr_on_ack=0.
  - pwr_on_req=1 → iso_en=0 and core_clk_en=1 on the next edge.
  - Next state is RST_HOLD if fuse_bypass=1, otherwise FUSE.
- FUSE:
  - fuse_pull_req=1; counter counts up from 0.
  - On fuse_pull_ack=1: fuse_pull_req=0 next cycle, go to RST_HOLD.
  - If the counter reaches FUSE_TMO_CYC-1 without an ack: fuse_err=1 (sticky until side_rst_b), fuse_pull_req=0, go to RST_HOLD.
- RST_HOLD:
  - core_rst_b=0 for exactly RST_HOLD_CYC cycles.
  - Then core_rst_b=1 and pwr_on_ack=1 on the same edge; go to ACTIVE.
- ACTIVE:
  - pwr_on_req=0 → DOWN_QSC. This takes priority over a simultaneous warm_rst_req.
  - Otherwise warm_rst_req=1 with warm_rst_ack=0 → WARM_QSC.
  - warm_rst_ack falls one cycle after warm_rst_req falls.
- WARM_QSC: quiesce_req=1 until quiesce_ack=1. Then quiesce_req=0, core_rst_b=0, go to WARM_HOLD.
- WARM_HOLD:
  - core_rst_b=0 for RST_HOLD_CYC cycles; then core_rst_b=1 and warm_rst_ack=1; go to ACTIVE.
  - Fuses are not re-pulled; core_clk_en stays 1.
- DOWN_QSC:
  - quiesce_req=1 until quiesce_ack=1.
  - Then, on a single edge: core_rst_b=0, core_clk_en=0, iso_en=1, pwr_on_ack=0, quiesce_req=0; go to OFF.
- pwr_on_req dropped before reaching ACTIVE (FUSE or RST_HOLD):
  - Abort: fuse_pull_req=0, core_rst_b=0, core_clk_en=0, iso_en=1; go to OFF.
  - No ack is issued.
- pwr_on_req dropped in WARM_QSC or WARM_HOLD:
  - Go to OFF as for the abort case.
  - warm_rst_ack stays 0 and pwr_on_ack goes to 0.
- Warm reset handshake outside ACTIVE: warm_rst_req is ignored (no ack) in every state other than ACTIVE.
- OFF re-entry guard: OFF does not re-start while pwr_on_ack=1; this cannot occur by construction.
- Counter: saturating, cleared on every state entry.
- Async reset: side_rst_b low at any point forces the reset values immediately, independent of side_clk.
- Invariants:
  - core_rst_b=1 implies core_clk_en=1 and iso_en=0.
  - quiesce_req and fuse_pull_req are never both 1.

Test Plan:
- Bypass power-up, RST_HOLD_CYC=16: fuse_bypass=1, pwr_on_req rises at cycle 0 → iso_en=0 and core_clk_en=1 at cycle 1; core_rst_b=1 and pwr_on_ack=1 at cycle 17; fuse_pull_req never asserts.
- Fuse pull: fuse_bypass=0, fuse_pull_ack returned 5 cycles after fuse_pull_req → fuse_pull_req falls the next cycle; core_rst_b releases 16 cycles later; fuse_err=0.
- Fuse timeout, FUSE_TMO_CYC=1024, no ack → fuse_err=1 after 1024 cycles in FUSE; power-up still completes; fuse_err stays 1 through a later power-down/power-up and clears only on side_rst_b.
- Warm reset in ACTIVE, quiesce_ack after 3 cycles → core_rst_b low for 16 cycles, core_clk_en stays 1, warm_rst_ack=1; warm_rst_ack falls 1 cycle after warm_rst_req falls; no fuse pull.
- Simultaneous pwr_on_req fall and warm_rst_req rise in ACTIVE → DOWN_QSC taken; warm_rst_ack never asserts; after quiesce_ack: core_clk_en=0, iso_en=1, pwr_on_ack=0, state=OFF.
- Abort and async reset: pwr_on_req falls during FUSE → OFF next cycle with fuse_pull_req=0 and no ack. side_rst_b pulsed low mid-WARM_HOLD → all outputs return to their reset values asynchronously.
